seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
Parametrised-width, handshaked successor to the team's combinational 16-function ALU. It keeps the existing 16 function codes as single-cycle operations and adds multi-cycle operations: an unsigned shift-add multiply and shifts by a variable amount. Operands are accepted with a valid/ready handshake, and each result is held until the consumer takes it. The block sits between the decode stage and writeback in the multi-cycle datapath.

Parameters:
DATA_WIDTH, 16, operand/result width in bits; must be a power of two, minimum 4
SHW, $clog2(DATA_WIDTH), width of the shift-amount field taken from B (derived; not overridden)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
in_valid  input  1  operands and func_code valid this cycle
in_ready  output  1  block can accept an operation
a  input  DATA_WIDTH  operand A
b  input  DATA_WIDTH  operand B
func_code  input  5  operation select
out_valid  output  1  result fields valid
out_ready  input  1  consumer takes the result
c  output  DATA_WIDTH  result
overflow_flag  output  1  overflow for ADD/SUB/MUL; 0 for all other ops
zero_flag  output  1  c == 0
illegal_flag  output  1  func_code was unassigned

Behaviour:
- Function codes:
  - 0 ADD, 1 SUB, 2 ID, 3 NOT, 4 AND, 5 OR, 6 NAND, 7 NOR, 8 XOR, 9 XNOR.
  - 10 LLS, 11 LRS, 12 ALS, 13 ARS: shift by 1.
  - 14 TCP: two's complement, ~A+1. 15 ZERO.
  - 16 MUL. 17 SHLV, 18 SHRV, 19 SARV: shift A by b[SHW-1:0].
  - 20-31: illegal.
- Arithmetic:
  - ADD: signed overflow = operands have equal sign and result sign differs.
  - SUB: signed overflow = operand signs differ and result sign differs from A.
  - ARS/SARV: replicate A's MSB.
  - MUL: unsigned; c = low DATA_WIDTH bits of the product; overflow_flag = high half nonzero.
  - All arithmetic wraps modulo 2^DATA_WIDTH.
- Operands a, b and func_code are registered on acceptance. Inputs may change afterwards without effect.
- State machine IDLE / BUSY / DONE:
  - IDLE: in_ready=1. The handshake completes when in_valid & in_ready at a rising edge.
  - IDLE -> DONE: on accept of codes 0-15, codes 20-31, or SHLV/SHRV/SARV with amount 0.
  - IDLE -> BUSY: on accept of MUL, or a variable shift with amount > 0. The iteration counter is loaded with DATA_WIDTH for MUL, or with the shift amount.
  - BUSY: one iteration per clock. MUL adds the shifted multiplicand when the current multiplier bit is set. Variable shifts move one bit per clock. After the last iteration -> DONE.
  - DONE: out_valid=1. c and the flags are stable and unchanged while out_ready=0. out_valid & out_ready at an edge -> IDLE.
- Latency, in rising edges from the accepting edge to out_valid high:
  - 1 for single-cycle ops.
  - DATA_WIDTH for MUL.
  - max(1, amount) for variable shifts.
- in_ready=0 in BUSY and DONE, unless the optional feature is compiled in.
- Illegal code: c=0, overflow_flag=0, zero_flag=1, illegal_flag=1; normal 1-cycle latency.
- zero_flag is computed from the final c.
- illegal_flag=0 for legal codes.
- out_valid=0 in IDLE and BUSY; c and the flags are don't-care while out_valid=0.
- Reset (async assert, any state including mid-BUSY): state=IDLE, in_ready=1 after reset, out_valid=0, c=0, all flags=0, counter=0. Any in-flight operation is discarded.

Optional Feature:
SEQ_ALU_PASSTHRU_EN
- Defined: in DONE, in_ready = out_ready. A result drain and a new accept at the same edge go directly to DONE or BUSY, as for an IDLE accept. Single-cycle ops then sustain one result per clock.
- Undefined: in_ready=1 only in IDLE; single-cycle throughput is one result per 2 clocks.

Test Plan:
- Reset mid-MUL: assert reset_n=0 during BUSY -> out_valid=0, c=0, in_ready=1 after release; the next ADD completes normally.
- DATA_WIDTH=16, ADD a=0x7FFF b=0x0001 -> c=0x8000, overflow=1, zero=0, latency 1. SUB a=0x8000 b=0x0001 -> c=0x7FFF, overflow=1.
- MUL a=0x0012 b=0x0034 -> c=0x03A8, overflow=0, out_valid 16 edges after accept. MUL a=0x0100 b=0x0100 -> c=0x0000, overflow=1, zero=1.
- SARV a=0x8000 b=0x0004 -> c=0xF800 after 4 edges. SHLV b=0x0010 (amount field 0) -> c=a after 1 edge. SHRV a=0x00F0 b=0x0003 -> c=0x001E.
- Backpressure: hold out_ready=0 for 5 cycles after a NOT result -> c and flags stable, in_ready=0, new in_valid ignored. Raise out_ready -> IDLE next edge.
- func_code=25 -> c=0, illegal=1, zero=1. With SEQ_ALU_PASSTHRU_EN and out_ready held 1: 4 back-to-back XORs give 4 results on 4 consecutive cycles.

Source files
------------

// File: rtl/seq_alu_if.sv
// Handshake bus for seq_alu: operand channel (in_*) and result channel (out_*).
interface seq_alu_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic [4:0]            func_code;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] c;
  logic                  overflow_flag;
  logic                  zero_flag;
  logic                  illegal_flag;

  modport master (
    output in_valid, a, b, func_code, out_ready,
    input  in_ready, out_valid, c, overflow_flag, zero_flag, illegal_flag
  );

  modport slave (
    input  in_valid, a, b, func_code, out_ready,
    output in_ready, out_valid, c, overflow_flag, zero_flag, illegal_flag
  );
endinterface

// File: rtl/seq_alu.sv
// Handshaked ALU: 16 single-cycle functions plus shift-add MUL and variable shifts.
// Define SEQ_ALU_PASSTHRU_EN to let a new operation be accepted while a result drains.
module seq_alu #(
  parameter int DATA_WIDTH = 16
) (
  input logic      clk,
  input logic      reset_n,
  seq_alu_if.slave bus
);
  localparam int SHW = $clog2(DATA_WIDTH);
  localparam int CW  = SHW + 1;
  localparam int MSB = DATA_WIDTH - 1;

  localparam logic [4:0] FN_MUL  = 5'd16;
  localparam logic [4:0] FN_SHLV = 5'd17;
  localparam logic [4:0] FN_SHRV = 5'd18;
  localparam logic [4:0] FN_SARV = 5'd19;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  stateReg;
  state_t                  stateNext;
  logic [4:0]              funcReg;
  logic [DATA_WIDTH-1:0]   mcandReg;
  logic [DATA_WIDTH-1:0]   accHiReg;
  logic [DATA_WIDTH-1:0]   accLoReg;
  logic [DATA_WIDTH-1:0]   shiftReg;
  logic [CW-1:0]           cntReg;
  logic [DATA_WIDTH-1:0]   cReg;
  logic                    ovfReg;
  logic                    zeroReg;
  logic                    illReg;

  logic                    inReady;
  logic                    outValid;
  logic                    accept;
  logic                    isVarShift;
  logic                    goBusy;
  logic                    lastIter;
  logic [SHW-1:0]          amount;
  logic [DATA_WIDTH-1:0]   quickC;
  logic                    quickOvf;
  logic                    quickIll;
  logic [2*DATA_WIDTH-1:0] mulFirst;
  logic [2*DATA_WIDTH-1:0] mulNext;
  logic [DATA_WIDTH-1:0]   shiftFirst;
  logic [DATA_WIDTH-1:0]   shiftNext;
  logic [DATA_WIDTH-1:0]   busyC;
  logic                    busyOvf;

  // One shift-add step on the {hi, lo} product pair; lo starts as the multiplier.
  function automatic logic [2*DATA_WIDTH-1:0] mulStep(
    input logic [DATA_WIDTH-1:0] hi,
    input logic [DATA_WIDTH-1:0] lo,
    input logic [DATA_WIDTH-1:0] mcand
  );
    logic [DATA_WIDTH:0] sum;
    sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : {(DATA_WIDTH+1){1'b0}});
    return {sum, lo[DATA_WIDTH-1:1]};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shiftStep(
    input logic [DATA_WIDTH-1:0] v,
    input logic [4:0]            f
  );
    case (f)
      FN_SHLV: return {v[DATA_WIDTH-2:0], 1'b0};
      FN_SHRV: return {1'b0, v[MSB:1]};
      default: return {v[MSB], v[MSB:1]};
    endcase
  endfunction

  assign amount     = bus.b[SHW-1:0];
  assign isVarShift = (bus.func_code == FN_SHLV) || (bus.func_code == FN_SHRV) ||
                      (bus.func_code == FN_SARV);
  // The accepting edge already performs the first iteration, so a 1-bit shift needs no BUSY.
  assign goBusy     = (bus.func_code == FN_MUL) || (isVarShift && (amount > SHW'(1)));
  assign accept     = bus.in_valid && inReady;
  assign lastIter   = (cntReg == CW'(2));

  assign mulFirst   = mulStep({DATA_WIDTH{1'b0}}, bus.b, bus.a);
  assign shiftFirst = shiftStep(bus.a, bus.func_code);
  assign mulNext    = mulStep(accHiReg, accLoReg, mcandReg);
  assign shiftNext  = shiftStep(shiftReg, funcReg);

  always_comb begin
    quickC   = '0;
    quickOvf = 1'b0;
    quickIll = 1'b0;
    case (bus.func_code)
      5'd0: begin
        quickC   = bus.a + bus.b;
        quickOvf = (bus.a[MSB] == bus.b[MSB]) && (quickC[MSB] != bus.a[MSB]);
      end
      5'd1: begin
        quickC   = bus.a - bus.b;
        quickOvf = (bus.a[MSB] != bus.b[MSB]) && (quickC[MSB] != bus.a[MSB]);
      end
      5'd2:  quickC = bus.a;
      5'd3:  quickC = ~bus.a;
      5'd4:  quickC = bus.a & bus.b;
      5'd5:  quickC = bus.a | bus.b;
      5'd6:  quickC = ~(bus.a & bus.b);
      5'd7:  quickC = ~(bus.a | bus.b);
      5'd8:  quickC = bus.a ^ bus.b;
      5'd9:  quickC = ~(bus.a ^ bus.b);
      5'd10: quickC = {bus.a[DATA_WIDTH-2:0], 1'b0};
      5'd11: quickC = {1'b0, bus.a[MSB:1]};
      5'd12: quickC = {bus.a[DATA_WIDTH-2:0], 1'b0};
      5'd13: quickC = {bus.a[MSB], bus.a[MSB:1]};
      5'd14: quickC = ~bus.a + 1'b1;
      5'd15: quickC = '0;
      5'd16: quickC = '0;
      5'd17, 5'd18, 5'd19: quickC = (amount == '0) ? bus.a : shiftFirst;
      default: quickIll = 1'b1;
    endcase
  end

  always_comb begin
    busyC   = shiftNext;
    busyOvf = 1'b0;
    if (funcReg == FN_MUL) begin
      busyC   = mulNext[MSB:0];
      busyOvf = |mulNext[2*DATA_WIDTH-1:DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE: if (accept) stateNext = goBusy ? BUSY : DONE;
      BUSY: if (lastIter) stateNext = DONE;
      DONE: if (bus.out_ready) stateNext = accept ? (goBusy ? BUSY : DONE) : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    outValid = (stateReg == DONE);
`ifdef SEQ_ALU_PASSTHRU_EN
    inReady  = (stateReg == IDLE) || ((stateReg == DONE) && bus.out_ready);
`else
    inReady  = (stateReg == IDLE);
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      funcReg  <= '0;
      mcandReg <= '0;
      accHiReg <= '0;
      accLoReg <= '0;
      shiftReg <= '0;
      cntReg   <= '0;
      cReg     <= '0;
      ovfReg   <= 1'b0;
      zeroReg  <= 1'b0;
      illReg   <= 1'b0;
    end else if (accept) begin
      funcReg              <= bus.func_code;
      mcandReg             <= bus.a;
      {accHiReg, accLoReg} <= mulFirst;
      shiftReg             <= shiftFirst;
      cntReg               <= (bus.func_code == FN_MUL) ? CW'(DATA_WIDTH) : CW'(amount);
      if (!goBusy) begin
        cReg    <= quickC;
        ovfReg  <= quickOvf;
        zeroReg <= (quickC == '0);
        illReg  <= quickIll;
      end
    end else if (stateReg == BUSY) begin
      {accHiReg, accLoReg} <= mulNext;
      shiftReg             <= shiftNext;
      cntReg               <= cntReg - CW'(1);
      if (lastIter) begin
        cReg    <= busyC;
        ovfReg  <= busyOvf;
        zeroReg <= (busyC == '0);
        illReg  <= 1'b0;
      end
    end
  end

  assign bus.in_ready      = inReady;
  assign bus.out_valid     = outValid;
  assign bus.c             = cReg;
  assign bus.overflow_flag = ovfReg;
  assign bus.zero_flag     = zeroReg;
  assign bus.illegal_flag  = illReg;
endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: the driver queues expected results, a negedge monitor checks them.
module tb_seq_alu;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  seq_alu_if #(.DATA_WIDTH(DW)) bus ();

  seq_alu #(.DATA_WIDTH(DW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] c;
    logic          ovf;
    logic          zero;
    logic          ill;
    int            lat;
    time           tAcc;
    string         name;
  } exp_t;

  exp_t expQ[$];
  int   errors = 0;
  int   checks = 0;
  bit   seenFront = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  // Monitor: latency on first sight, hold checks under backpressure, full compare on handshake.
  always @(negedge clk) begin
    if (reset_n && bus.out_valid) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got c=0x%0h, expected no result", bus.c);
      end else begin
        if (!seenFront) begin
          seenFront = 1'b1;
          check({expQ[0].name, "_latency"}, 32'(($time - expQ[0].tAcc + 5) / 10),
                32'(expQ[0].lat));
        end
        if (!bus.out_ready) begin
          check({expQ[0].name, "_hold_c"}, 32'(bus.c), 32'(expQ[0].c));
          check({expQ[0].name, "_hold_zero"}, 32'(bus.zero_flag), 32'(expQ[0].zero));
          check({expQ[0].name, "_hold_in_ready"}, 32'(bus.in_ready), 32'(0));
        end else begin
          check({expQ[0].name, "_c"}, 32'(bus.c), 32'(expQ[0].c));
          check({expQ[0].name, "_ovf"}, 32'(bus.overflow_flag), 32'(expQ[0].ovf));
          check({expQ[0].name, "_zero"}, 32'(bus.zero_flag), 32'(expQ[0].zero));
          check({expQ[0].name, "_ill"}, 32'(bus.illegal_flag), 32'(expQ[0].ill));
          $display("%0t %s c=0x%04h ovf=%b zero=%b ill=%b", $time, expQ[0].name, bus.c,
                   bus.overflow_flag, bus.zero_flag, bus.illegal_flag);
          void'(expQ.pop_front());
          seenFront = 1'b0;
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [4:0] f, input logic [DW-1:0] av, input logic [DW-1:0] bv,
                       input logic [DW-1:0] ec, input logic eo, input logic ez, input logic ei,
                       input int lat, input string nm);
    exp_t e;
    int   w;
    bus.in_valid  = 1'b1;
    bus.func_code = f;
    bus.a         = av;
    bus.b         = bv;
    w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_accept: in_ready=0 after %0d cycles, expected 1", nm, w);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e.c = ec; e.ovf = eo; e.zero = ez; e.ill = ei; e.lat = lat; e.tAcc = $time; e.name = nm;
    expQ.push_back(e);
    #1;
    bus.in_valid  = 1'b0;
    bus.a         = ~av;
    bus.b         = ~bv;
    bus.func_code = 5'd1;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (expQ.size() != 0 && w < 500) begin
      @(posedge clk);
      w++;
    end
    #1;
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", expQ.size());
      expQ.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    time t0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.func_code = '0;
    bus.out_ready = 1'b1;
    reset_n       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(bus.out_valid), 32'(0));
    check("reset_in_ready", 32'(bus.in_ready), 32'(1));
    check("reset_c", 32'(bus.c), 32'(0));
    check("reset_flags", 32'({bus.overflow_flag, bus.zero_flag, bus.illegal_flag}), 32'(0));
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    issue(5'd0,  16'h7FFF, 16'h0001, 16'h8000, 1'b1, 1'b0, 1'b0, 1,  "add_ovf");
    issue(5'd1,  16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1,  "sub_ovf");
    issue(5'd0,  16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0, 1,  "add_wrap_zero");
    issue(5'd6,  16'hF0F0, 16'hFF00, 16'h0FFF, 1'b0, 1'b0, 1'b0, 1,  "nand");
    issue(5'd9,  16'hAAAA, 16'hAAAA, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1,  "xnor");
    issue(5'd13, 16'h8002, 16'h0000, 16'hC001, 1'b0, 1'b0, 1'b0, 1,  "ars");
    issue(5'd14, 16'h0001, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1,  "tcp");
    issue(5'd15, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b1, 1'b0, 1,  "zero");
    issue(5'd16, 16'h0012, 16'h0034, 16'h03A8, 1'b0, 1'b0, 1'b0, 16, "mul_small");
    issue(5'd16, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b1, 1'b0, 16, "mul_ovf");
    issue(5'd19, 16'h8000, 16'h0004, 16'hF800, 1'b0, 1'b0, 1'b0, 4,  "sarv4");
    issue(5'd17, 16'h1234, 16'h0010, 16'h1234, 1'b0, 1'b0, 1'b0, 1,  "shlv0");
    issue(5'd18, 16'h00F0, 16'h0003, 16'h001E, 1'b0, 1'b0, 1'b0, 3,  "shrv3");
    issue(5'd17, 16'h0001, 16'h000F, 16'h8000, 1'b0, 1'b0, 1'b0, 15, "shlv15");
    issue(5'd18, 16'h8000, 16'h0001, 16'h4000, 1'b0, 1'b0, 1'b0, 1,  "shrv1");
    issue(5'd25, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b1, 1'b1, 1,  "illegal25");
    drain();

    // Backpressure: result held, new request ignored.
    bus.out_ready = 1'b0;
    issue(5'd3, 16'h00FF, 16'h0000, 16'hFF00, 1'b0, 1'b0, 1'b0, 1, "not_bp");
    bus.in_valid  = 1'b1;
    bus.func_code = 5'd0;
    bus.a         = 16'h0001;
    bus.b         = 16'h0001;
    repeat (5) @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_out_valid", 32'(bus.out_valid), 32'(0));
    check("bp_release_in_ready", 32'(bus.in_ready), 32'(1));
    drain();

    // Reset during a MUL discards it.
    bus.in_valid  = 1'b1;
    bus.func_code = 5'd16;
    bus.a         = 16'h0003;
    bus.b         = 16'h0005;
    @(negedge clk);
    check("mul_rst_accept_ready", 32'(bus.in_ready), 32'(1));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("mul_rst_out_valid", 32'(bus.out_valid), 32'(0));
    check("mul_rst_c", 32'(bus.c), 32'(0));
    check("mul_rst_in_ready", 32'(bus.in_ready), 32'(1));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    issue(5'd0, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0, 1'b0, 1, "add_after_rst");
    drain();

    // Back-to-back XORs; accept spacing depends on passthrough.
    t0 = $time;
    issue(5'd8, 16'h1234, 16'h00FF, 16'h12CB, 1'b0, 1'b0, 1'b0, 1, "xor0");
    issue(5'd8, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, 1, "xor1");
    issue(5'd8, 16'hA5A5, 16'h5A5A, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1, "xor2");
    issue(5'd8, 16'h0F0F, 16'h0101, 16'h0E0E, 1'b0, 1'b0, 1'b0, 1, "xor3");
`ifdef SEQ_ALU_PASSTHRU_EN
    check("xor_burst_span", 32'($time - t0), 32'(40));
`else
    check("xor_burst_span", 32'($time - t0), 32'(70));
`endif
    drain();
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
